sky130_as_sc_hs__pipereg: RTL



---
 rtl/sky130_as_sc_hs__pipereg.sv | 74 +++++++
 1 files changed

// File: rtl/sky130_as_sc_hs__pipereg.sv
// Scannable STAGES-deep pipeline register bank with per-stage valid bit.
// Reset, scan shift, functional advance and hold are mutually exclusive per edge.
module sky130_as_sc_hs__pipereg #(
  parameter int                 WIDTH     = 8,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  input  logic             SCE,
  input  logic             SCD,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT,
  output logic             SCQ,
  input  logic             VPWR,
  input  logic             VGND,
  input  logic             VPB,
  input  logic             VNB
);

  localparam int SW = WIDTH + 1;
  localparam int L  = STAGES * SW;

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sky130_as_sc_hs__pipereg: WIDTH=%0d outside 1..64", WIDTH);
  end
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("sky130_as_sc_hs__pipereg: STAGES=%0d outside 1..16", STAGES);
  end

  // Supply/bulk pins carry no logic.
  logic unused_supply;
  assign unused_supply = &{1'b0, VPWR, VGND, VPB, VNB};

  // Stage k occupies chain[k*SW +: SW] as {v[k], dat[k]}; index order is scan order.
  logic [L-1:0] chain;
  logic [L-1:0] chain_nxt;
  logic [L-1:0] chain_rst;

  always_comb begin
    chain_rst = '0;
    for (int k = 0; k < STAGES; k++) begin
      chain_rst[k*SW +: SW] = {1'b0, RESET_VAL};
    end
  end

  always_comb begin
    chain_nxt = chain;
    if (SCE) begin
      chain_nxt = {chain[L-2:0], SCD};
    end else if (EN) begin
      chain_nxt[0 +: SW] = {VLD_IN, D};
      for (int k = 1; k < STAGES; k++) begin
        chain_nxt[k*SW +: SW] = chain[(k-1)*SW +: SW];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      chain <= chain_rst;
    end else begin
      chain <= chain_nxt;
    end
  end

  assign Q       = chain[(STAGES-1)*SW +: WIDTH];
  assign VLD_OUT = chain[L-1];
  assign SCQ     = chain[L-1];

endmodule
